// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipe: mode encoding and
// the buffer entry layout for the default 16 -> 32 bit configuration.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO   = 2'd0,
        EXT_SIGN   = 2'd1,
        EXT_UPPER  = 2'd2,
        EXT_BRANCH = 2'd3
    } ext_mode_t;

    localparam int EXT_DEF_IN_W  = 16;
    localparam int EXT_DEF_OUT_W = 32;

    // Buffer entry for the default widths; the top re-declares the same
    // shape locally so it can follow OUT_W.
    typedef struct packed {
        ext_mode_t                mode;
        logic [EXT_DEF_OUT_W-1:0] data;
    } ext_ent_t;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Producer/consumer handshake bundle around the immediate-extension pipe.
interface imm_ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       ExtMode;
    logic [IN_W-1:0]  immediate;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] DataOut;
    logic [1:0]       ExtMode_out;

    // Pipe side
    modport slave (
        input  in_valid, ExtMode, immediate, out_ready,
        output in_ready, out_valid, DataOut, ExtMode_out
    );

    // Driver / consumer side
    modport master (
        output in_valid, ExtMode, immediate, out_ready,
        input  in_ready, out_valid, DataOut, ExtMode_out
    );
endinterface

// File: rtl/ext_skid_buf.sv
// Generic 2-entry FIFO-ordered valid/ready buffer. in_ready comes only from
// registered occupancy (and reset), never from out_ready, so the two sides
// stall independently.
module ext_skid_buf #(
    parameter int W = 34
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [1:0][W-1:0] mem;
    logic              hptr;
    logic              tptr;
    logic [1:0]        cnt;
    logic              acc;
    logic              drn;

    assign in_ready  = RST && (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign acc       = in_valid && in_ready;
    assign drn       = out_valid && out_ready;
    assign out_data  = mem[hptr];

    // Occupancy, pointers and storage; the head slot is only rewritten
    // after it drains, which keeps out_data stable under stall.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt  <= 2'd0;
            hptr <= 1'b0;
            tptr <= 1'b0;
            mem  <= '0;
        end else begin
            if (acc) begin
                mem[tptr] <= in_data;
                tptr      <= ~tptr;
            end
            if (drn) hptr <= ~hptr;
            if (acc && !drn)      cnt <= cnt + 2'd1;
            else if (drn && !acc) cnt <= cnt - 2'd1;
        end
    end
endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extension: converts the immediate at accept time and
// queues {mode, result} through a 2-entry buffer toward the operand stage.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input logic           CLK,
    input logic           RST,
    imm_ext_pipe_if.slave bus
);
    // Width sanity: branch offsets need two spare bits above the immediate.
    if (IN_W < 2) begin : g_bad_in_w
        $error("imm_ext_pipe: IN_W must be >= 2");
    end
    if (OUT_W < IN_W + 2) begin : g_bad_out_w
        $error("imm_ext_pipe: OUT_W must be >= IN_W + 2");
    end

    localparam int PAD = OUT_W - IN_W;

    typedef struct packed {
        ext_mode_t        mode;
        logic [OUT_W-1:0] data;
    } ent_t;

    ext_mode_t        mode;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    ent_t             ent_in;
    ent_t             ent_out;

    assign mode = ext_mode_t'(bus.ExtMode);
    assign zext = {{PAD{1'b0}}, bus.immediate};
    assign sext = {{PAD{bus.immediate[IN_W-1]}}, bus.immediate};

    // Mode-dependent conversion feeding the buffer tail.
    always_comb begin
        ent_in.mode = mode;
        ent_in.data = zext;
        unique case (mode)
            EXT_ZERO:   ent_in.data = zext;
            EXT_SIGN:   ent_in.data = sext;
            EXT_UPPER:  ent_in.data = {bus.immediate, {PAD{1'b0}}};
            EXT_BRANCH: ent_in.data = sext << 2;
            default:    ent_in.data = zext;
        endcase
    end

    ext_skid_buf #(.W($bits(ent_t))) u_buf (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (ent_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (ent_out)
    );

    assign bus.DataOut     = ent_out.data;
    assign bus.ExtMode_out = ent_out.mode;
endmodule
